mem_ctrl: RTL



---
 rtl/mem_ctrl_pkg.sv | 10 +
 rtl/mem_ctrl_if.sv | 26 ++
 rtl/mem_arb.sv | 37 +++
 rtl/mem_ctrl.sv | 79 +++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings, FSM states and helpers for the memory controller
package mem_ctrl_pkg;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_WORD_ALT} size_t;
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR = 1;
    function automatic logic [2:0] nbytes(input logic [1:0] sz);
        return sz == SZ_BYTE ? 3'd1 : sz == SZ_HALF ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: requester handshake plus byte-wide RAM port
interface mem_ctrl_if #(
    parameter int NCH = 2,
    parameter int AW = 32
);
    logic [NCH-1:0] req;
    logic [NCH*AW-1:0] req_a;
    logic [NCH-1:0] req_wr;
    logic [NCH*2-1:0] req_sz;
    logic [NCH*32-1:0] req_wn;
    logic [NCH-1:0] kill;
    logic [NCH-1:0] ack;
    logic [31:0] rn;
    logic [AW-1:0] mem_a;
    logic mem_wr;
    logic [7:0] mem_wn;
    logic [7:0] mem_rn;
    modport slave (
        input req, req_a, req_wr, req_sz, req_wn, kill, mem_rn,
        output ack, rn, mem_a, mem_wr, mem_wn
    );
    modport master (
        output req, req_a, req_wr, req_sz, req_wn, kill, mem_rn,
        input ack, rn, mem_a, mem_wr, mem_wn
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: fixed (highest index wins) or round-robin one-hot arbiter
module mem_arb import mem_ctrl_pkg::*; #(
    parameter int NCH = 2,
    parameter int RR = ARB_FIXED,
    localparam int GW = NCH > 1 ? $clog2(NCH) : 1
) (
    input logic clk,
    input logic rst,
    input logic [NCH-1:0] req,
    input logic en,
    output logic [NCH-1:0] gnt,
    output logic [GW-1:0] idx
);
    logic [GW-1:0] ptr;
    // pick a winner; the last hit in each loop has priority
    always_comb begin
        gnt = '0;
        idx = '0;
        if (RR == ARB_RR) begin
            for (int i = NCH; i >= 1; i--)
                if (req[(int'(ptr) + i) % NCH]) begin
                    gnt = NCH'(1) << ((int'(ptr) + i) % NCH);
                    idx = GW'((int'(ptr) + i) % NCH);
                end
        end else begin
            for (int i = 0; i < NCH; i++)
                if (req[i]) begin
                    gnt = NCH'(1) << i;
                    idx = GW'(i);
                end
        end
    end
    // remember last winner so round-robin starts just past it
    always_ff @(posedge clk)
        if (rst) ptr <= GW'(NCH - 1);
        else if (en) ptr <= idx;
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates NCH requesters onto a byte-wide RAM, serialising little-endian
module mem_ctrl import mem_ctrl_pkg::*; #(
    parameter int NCH = 2,
    parameter int AW = 32,
    parameter int RD_LAT = 1,
    parameter int RR = ARB_FIXED
) (
    input logic clk,
    input logic rst,
    mem_ctrl_if.slave bus
);
    localparam int GW = NCH > 1 ? $clog2(NCH) : 1;
    localparam int CW = $clog2(RD_LAT + 8);
    state_t state, state_n;
    logic [NCH-1:0] live, gnt, gsel;
    logic [GW-1:0] gidx;
    logic [CW-1:0] cnt, last_a, last_c;
    logic [2:0] n;
    logic [31:0] wdata;
    logic wr, grant, kill_rd, more;
    logic [1:0] wsel, rsel;

    assign live = bus.req & ~bus.kill;
    assign grant = state == IDLE && |live;
    assign kill_rd = (state == BUSY || state == DRAIN) && !wr && |(bus.kill & gsel);
    assign last_a = CW'(n) - CW'(1);
    assign last_c = last_a + CW'(RD_LAT);
    assign more = state == BUSY && state_n == BUSY;
    assign wsel = cnt[1:0] + 2'd1;
    assign rsel = 2'(cnt - CW'(RD_LAT));

    mem_arb #(.NCH(NCH), .RR(RR)) u_arb (
        .clk(clk), .rst(rst), .req(live), .en(grant), .gnt(gnt), .idx(gidx)
    );

    // state register
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    // cnt counts cycles since the first address; reads finish once the last byte is captured
    always_comb begin
        state_n = state;
        if (state == IDLE && grant) state_n = BUSY;
        else if (state == DONE || kill_rd) state_n = IDLE;
        else if (state == BUSY && cnt == last_a) state_n = (wr || cnt == last_c) ? DONE : DRAIN;
        else if (state == DRAIN && cnt == last_c) state_n = DONE;
    end

    // latch the granted request, drive the RAM port and assemble read data
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ack <= '0;
            bus.rn <= '0;
            bus.mem_a <= '0;
            bus.mem_wr <= 1'b0;
            bus.mem_wn <= '0;
            gsel <= '0;
            wr <= 1'b0;
            n <= 3'd0;
            wdata <= '0;
            cnt <= '0;
        end else begin
            bus.ack <= state_n == DONE ? gsel : '0;
            cnt <= grant ? '0 : cnt + CW'(1);
            bus.mem_a <= grant ? bus.req_a[AW*gidx +: AW] : more ? bus.mem_a + AW'(1) : '0;
            bus.mem_wr <= grant ? bus.req_wr[gidx] : more && wr;
            bus.mem_wn <= grant && bus.req_wr[gidx] ? bus.req_wn[32*gidx +: 8] :
                          more && wr ? wdata[8*wsel +: 8] : '0;
            if (grant) begin
                gsel <= gnt;
                wr <= bus.req_wr[gidx];
                n <= nbytes(bus.req_sz[2*gidx +: 2]);
                wdata <= bus.req_wn[32*gidx +: 32];
                bus.rn <= '0;
            end else if ((state == BUSY || state == DRAIN) && !wr && cnt >= CW'(RD_LAT))
                bus.rn[8*rsel +: 8] <= bus.mem_rn;
        end
    end
endmodule
